// File: rtl/piece_queue_ctrl.sv
// Piece sequencer: preview queue, active piece and one hold slot, with
// request/ack handshakes toward the game FSM and display outputs.
module piece_queue_ctrl #(
  parameter int DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         rand_piece,
  input  logic               spawn_req,
  output logic               spawn_ack,
  input  logic               hold_req,
  output logic               hold_ack,
  output logic               hold_rej,
  output logic [2:0]         active_piece,
  output logic               active_valid,
  output logic [2:0]         hold_piece,
  output logic               hold_valid,
  output logic               hold_used,
  output logic [3*DEPTH-1:0] preview,
  output logic               ready
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_FILL,
    S_IDLE,
    S_SPAWN,
    S_HOLD
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_fill_cnt;
  logic [2:0]     r_queue [DEPTH];
  logic [2:0]     r_active;
  logic           r_active_valid;
  logic [2:0]     r_hold;
  logic           r_hold_valid;
  logic           r_hold_used;
  logic           r_hold_rej;

  logic [2:0]     w_rand;
  logic           w_fill_last;
  logic           w_do_spawn;
  logic           w_do_hold;
  logic           w_do_rej;
  logic           w_shift;

  // Index 7 is not a piece; fold it onto 0 before it can be stored.
  assign w_rand      = (rand_piece == 3'd7) ? 3'd0 : rand_piece;
  assign w_fill_last = (r_fill_cnt == CW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_do_spawn  = 1'b0;
    w_do_hold   = 1'b0;
    w_do_rej    = 1'b0;
    unique case (r_state)
      S_FILL: begin
        if (w_fill_last) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (spawn_req) begin
          w_do_spawn  = 1'b1;
          w_state_nxt = S_SPAWN;
        end else if (hold_req) begin
          if (r_hold_used || !r_active_valid) begin
            w_do_rej = 1'b1;
          end else begin
            w_do_hold   = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_SPAWN, S_HOLD: w_state_nxt = S_IDLE;
      default:         w_state_nxt = S_FILL;
    endcase
  end

  // A first hold pulls the next piece from the queue exactly like a spawn.
  assign w_shift = w_do_spawn | (w_do_hold & ~r_hold_valid);

  // NOTE: the queue is a handful of flops whose contents are visible on the
  // preview outputs, so it is cleared on reset like any other state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill_cnt     <= '0;
      for (int i = 0; i < DEPTH; i++) r_queue[i] <= 3'd0;
      r_active       <= 3'd0;
      r_active_valid <= 1'b0;
      r_hold         <= 3'd0;
      r_hold_valid   <= 1'b0;
      r_hold_used    <= 1'b0;
      r_hold_rej     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the shift and swap below read the
      // pre-edge values of every register, so ordering here does not matter.
      r_hold_rej <= w_do_rej;

      if (r_state == S_FILL) begin
        r_queue[r_fill_cnt] <= w_rand;
        r_fill_cnt          <= w_fill_last ? '0 : r_fill_cnt + CW'(1);
      end

      if (w_shift) begin
        r_active       <= r_queue[0];
        r_active_valid <= 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) r_queue[i] <= r_queue[i+1];
        r_queue[DEPTH-1] <= w_rand;
      end

      if (w_do_hold) begin
        r_hold       <= r_active;
        r_hold_valid <= 1'b1;
        if (r_hold_valid) r_active <= r_hold;
      end

      if (w_do_spawn) begin
        r_hold_used <= 1'b0;
      end else if (w_do_hold) begin
        r_hold_used <= 1'b1;
      end
    end
  end

  always_comb begin
    preview = '0;
    for (int i = 0; i < DEPTH; i++) preview[3*i +: 3] = r_queue[i];
  end

  assign spawn_ack    = (r_state == S_SPAWN);
  assign hold_ack     = (r_state == S_HOLD);
  assign hold_rej     = r_hold_rej;
  assign ready        = (r_state == S_IDLE);
  assign active_piece = r_active;
  assign active_valid = r_active_valid;
  assign hold_piece   = r_hold;
  assign hold_valid   = r_hold_valid;
  assign hold_used    = r_hold_used;

endmodule

// File: tb/tb_piece_queue_ctrl.sv
// Bench for piece_queue_ctrl: directed vector table, reset/fill corner
// sequences, then random traffic against a queue-based reference model.
module tb_piece_queue_ctrl;

  localparam int DEPTH = 3;
  localparam int PW    = 3 * DEPTH;

  logic          clk;
  logic          rst;
  logic [2:0]    rand_piece;
  logic          spawn_req;
  logic          hold_req;
  logic          spawn_ack;
  logic          hold_ack;
  logic          hold_rej;
  logic [2:0]    active_piece;
  logic          active_valid;
  logic [2:0]    hold_piece;
  logic          hold_valid;
  logic          hold_used;
  logic [PW-1:0] preview;
  logic          ready;

  piece_queue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .rand_piece   (rand_piece),
    .spawn_req    (spawn_req),
    .spawn_ack    (spawn_ack),
    .hold_req     (hold_req),
    .hold_ack     (hold_ack),
    .hold_rej     (hold_rej),
    .active_piece (active_piece),
    .active_valid (active_valid),
    .hold_piece   (hold_piece),
    .hold_valid   (hold_valid),
    .hold_used    (hold_used),
    .preview      (preview),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: mode 0=filling 1=idle 2=spawn ack 3=hold ack.
  int         m_mode;
  logic [2:0] m_q[$];
  logic [2:0] m_active, m_hold;
  logic       m_av, m_hv, m_used, m_rej;

  task automatic model_reset();
    m_mode = 0;
    m_q.delete();
    m_active = 0; m_hold = 0;
    m_av = 0; m_hv = 0; m_used = 0; m_rej = 0;
  endtask

  task automatic model_step();
    logic [2:0] p;
    logic [2:0] t;
    p = (rand_piece == 3'd7) ? 3'd0 : rand_piece;
    m_rej = 0;
    case (m_mode)
      0: begin
        m_q.push_back(p);
        if (m_q.size() == DEPTH) m_mode = 1;
      end
      1: begin
        if (spawn_req) begin
          m_active = m_q.pop_front();
          m_q.push_back(p);
          m_av = 1; m_used = 0; m_mode = 2;
        end else if (hold_req) begin
          if (m_used || !m_av) begin
            m_rej = 1;
          end else if (!m_hv) begin
            m_hold = m_active; m_hv = 1;
            m_active = m_q.pop_front();
            m_q.push_back(p);
            m_used = 1; m_mode = 3;
          end else begin
            t = m_active; m_active = m_hold; m_hold = t;
            m_used = 1; m_mode = 3;
          end
        end
      end
      default: m_mode = 1;
    endcase
  endtask

  function automatic logic [PW-1:0] m_preview();
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++)
      if (i < m_q.size()) v[3*i +: 3] = m_q[i];
    return v;
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ".ready"},        ready,        m_mode == 1);
    check({tag, ".spawn_ack"},    spawn_ack,    m_mode == 2);
    check({tag, ".hold_ack"},     hold_ack,     m_mode == 3);
    check({tag, ".hold_rej"},     hold_rej,     m_rej);
    check({tag, ".active_piece"}, active_piece, m_active);
    check({tag, ".active_valid"}, active_valid, m_av);
    check({tag, ".hold_piece"},   hold_piece,   m_hold);
    check({tag, ".hold_valid"},   hold_valid,   m_hv);
    check({tag, ".hold_used"},    hold_used,    m_used);
    check({tag, ".preview"},      preview,      m_preview());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          sp, hr;
    logic [2:0]    rp;
    logic          rdy, sa, ha, rj;
    logic [2:0]    act;
    logic          av;
    logic [2:0]    hld;
    logic          hv, used;
    logic [PW-1:0] prev;
  } vec_t;

  vec_t tbl[15];

  initial begin
    //            sp    hr    rp    rdy   sa    ha    rj    act   av    hld   hv    used  prev
    tbl[0]  = '{1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 9'o002};
    tbl[1]  = '{1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 9'o032};
    tbl[2]  = '{1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 9'o432};
    tbl[3]  = '{1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 9'o432};
    tbl[4]  = '{1'b1, 1'b0, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 9'o643};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 9'o643};
    tbl[6]  = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 3'd2, 1'b1, 1'b1, 9'o164};
    tbl[7]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd2, 1'b1, 1'b1, 9'o164};
    tbl[8]  = '{1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 1'b1, 9'o164};
    tbl[9]  = '{1'b1, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 3'd2, 1'b1, 1'b0, 9'o016};
    tbl[10] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 3'd2, 1'b1, 1'b0, 9'o016};
    tbl[11] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 3'd4, 1'b1, 1'b1, 9'o016};
    tbl[12] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 3'd4, 1'b1, 1'b1, 9'o016};
    tbl[13] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 1'b1, 3'd4, 1'b1, 1'b0, 9'o301};
    tbl[14] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 3'd4, 1'b1, 1'b0, 9'o301};

    rst = 1'b0; spawn_req = 1'b0; hold_req = 1'b0; rand_piece = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model("reset");
    rst = 1'b1;

    // Directed table: fill, early hold reject, spawn, hold, swap, 7->0, both requests.
    for (int r = 0; r < 15; r++) begin
      spawn_req = tbl[r].sp; hold_req = tbl[r].hr; rand_piece = tbl[r].rp;
      tick();
      check($sformatf("row%0d.ready", r),     ready,        tbl[r].rdy);
      check($sformatf("row%0d.spawn_ack", r), spawn_ack,    tbl[r].sa);
      check($sformatf("row%0d.hold_ack", r),  hold_ack,     tbl[r].ha);
      check($sformatf("row%0d.hold_rej", r),  hold_rej,     tbl[r].rj);
      check($sformatf("row%0d.active", r),    active_piece, tbl[r].act);
      check($sformatf("row%0d.act_valid", r), active_valid, tbl[r].av);
      check($sformatf("row%0d.hold", r),      hold_piece,   tbl[r].hld);
      check($sformatf("row%0d.hold_valid", r),hold_valid,   tbl[r].hv);
      check($sformatf("row%0d.hold_used", r), hold_used,    tbl[r].used);
      check($sformatf("row%0d.preview", r),   preview,      tbl[r].prev);
      compare_model($sformatf("row%0d.model", r));
    end

    // Reset asserted while in SPAWN clears everything without a clock edge.
    spawn_req = 1'b1; hold_req = 1'b0; rand_piece = 3'd5;
    tick();
    check("pre_rst.spawn_ack", spawn_ack, 1);
    rst = 1'b0;
    #1;
    model_reset();
    compare_model("rst_in_spawn");
    #1;
    rst = 1'b1;

    // spawn_req held through FILL: no ack until the queue is full.
    for (int c = 0; c < DEPTH + 2; c++) begin
      rand_piece = 3'($urandom_range(0, 7));
      tick();
      compare_model($sformatf("fill_spawn%0d", c));
    end
    spawn_req = 1'b0;
    tick();
    compare_model("fill_spawn_end");

    // Random traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        #2;
        model_reset();
        compare_model("rand_rst");
        rst = 1'b1;
      end
      spawn_req  = ($urandom_range(0, 3) == 0);
      hold_req   = ($urandom_range(0, 2) == 0);
      rand_piece = 3'($urandom_range(0, 7));
      tick();
      compare_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
